// File: rtl/key_sync_edge_counter.sv
// Key input front end: a two-flop synchronizer, then a registered edge detector,
// plus the debounce interval counter with wrap at CNT_MAX and a terminal-count flag.
module key_sync_edge_counter #(
    parameter int CNT_W   = 20,
    parameter int CNT_MAX = 999_999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_in,
    output logic             key,
    output logic             neg,
    output logic             pos,
    input  logic             cnt_en,
    input  logic             aclr,
    output logic [CNT_W-1:0] q,
    output logic             cout
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [1:0]       sync_reg;   // [0] = s0, [1] = s1
    logic [1:0]       edge_reg;   // [0] = d0, [1] = d1
    logic [CNT_W-1:0] q_reg;
    logic             clr_n;

    // Both chains reset to the idle (released) key level, so no edge is seen out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
            edge_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], key_in};
            edge_reg <= {edge_reg[0], sync_reg[1]};
        end
    end

    assign key = sync_reg[1];
    assign neg = edge_reg[1] & ~edge_reg[0];
    assign pos = ~edge_reg[1] & edge_reg[0];

    // aclr shares the asynchronous clear path with rst_n, so it wins over cnt_en
    // and clears q without waiting for a clock edge.
    assign clr_n = rst_n & ~aclr;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_reg <= '0;
        end else if (cnt_en) begin
            if (q_reg == MAX_VAL) begin
                q_reg <= '0;
            end else begin
                q_reg <= q_reg + ONE;
            end
        end
    end

    assign q    = q_reg;
    assign cout = cnt_en & (q_reg == MAX_VAL);

endmodule

// File: tb/tb_key_sync_edge_counter.sv
// Directed + randomized bench for key_sync_edge_counter with CNT_MAX = 9.
// Expected values come from a latency/interval model built from the key samples seen at each edge.
module tb_key_sync_edge_counter;

    localparam int CW   = 20;
    localparam int CMAX = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_in;
    logic          key, neg, pos;
    logic          cnt_en;
    logic          aclr;
    logic [CW-1:0] q;
    logic          cout;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: samples[0] is key_in taken at the latest edge, samples[i] i edges earlier.
    bit samples[$];
    int cnt_m;

    key_sync_edge_counter #(.CNT_W(CW), .CNT_MAX(CMAX)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .key    (key),
        .neg    (neg),
        .pos    (pos),
        .cnt_en (cnt_en),
        .aclr   (aclr),
        .q      (q),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        samples = '{1'b1, 1'b1, 1'b1, 1'b1};
        cnt_m   = 0;
    endfunction

    // key follows key_in one edge late; the edge pulse appears two edges after the sample.
    function automatic bit exp_key();
        return samples[1];
    endfunction
    function automatic bit exp_neg();
        return samples[3] && !samples[2];
    endfunction
    function automatic bit exp_pos();
        return !samples[3] && samples[2];
    endfunction
    function automatic bit exp_cout();
        return cnt_en && (cnt_m == CMAX);
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            samples.push_front(key_in);
            void'(samples.pop_back());
            if (aclr)        cnt_m = 0;
            else if (cnt_en) cnt_m = (cnt_m == CMAX) ? 0 : cnt_m + 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".key"},  {31'd0, key},  {31'd0, exp_key()});
        chk({tag, ".neg"},  {31'd0, neg},  {31'd0, exp_neg()});
        chk({tag, ".pos"},  {31'd0, pos},  {31'd0, exp_pos()});
        chk({tag, ".q"},    {12'd0, q},    cnt_m);
        chk({tag, ".cout"}, {31'd0, cout}, {31'd0, exp_cout()});
    endtask

    // One clock: model updates on the rising edge, DUT is checked on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_model(tag);
    endtask

    initial begin
        int nneg, npos, overlap;
        rst_n  = 1'b0;
        key_in = 1'b0;
        cnt_en = 1'b1;
        aclr   = 1'b0;
        model_reset();

        // Reset held with key_in low and counting requested
        repeat (3) @(negedge clk);
        chk("rst.key",  {31'd0, key},  32'd1);
        chk("rst.neg",  {31'd0, neg},  32'd0);
        chk("rst.pos",  {31'd0, pos},  32'd0);
        chk("rst.q",    {12'd0, q},    32'd0);
        chk("rst.cout", {31'd0, cout}, 32'd0);
        rst_n  = 1'b1;
        cnt_en = 1'b0;
        tick("rel1");
        chk("rel1.neg", {31'd0, neg}, 32'd0);
        tick("rel2");
        chk("rel2.key", {31'd0, key}, 32'd0);
        tick("rel3");
        chk("rel3.neg", {31'd0, neg}, 32'd1);
        tick("rel4");
        chk("rel4.neg", {31'd0, neg}, 32'd0);

        // Clean release then press
        key_in = 1'b1;
        repeat (6) tick("idle");
        key_in = 1'b0;
        tick("press1");
        chk("press1.key", {31'd0, key}, 32'd1);
        tick("press2");
        chk("press2.key", {31'd0, key}, 32'd0);
        tick("press3");
        chk("press3.neg", {31'd0, neg}, 32'd1);
        tick("press4");
        chk("press4.neg", {31'd0, neg}, 32'd0);
        repeat (8) tick("held");
        key_in = 1'b1;
        tick("up1");
        tick("up2");
        tick("up3");
        chk("up3.pos", {31'd0, pos}, 32'd1);
        tick("up4");
        chk("up4.pos", {31'd0, pos}, 32'd0);

        // Bounce: 0,1,0 each for two cycles, then settle low
        nneg = 0; npos = 0; overlap = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 6) key_in = (i / 2 == 1) ? 1'b1 : 1'b0;
            else       key_in = 1'b0;
            tick("bounce");
            nneg += int'(neg);
            npos += int'(pos);
            overlap += int'(neg & pos);
        end
        chk("bounce.neg_cnt", nneg, 32'd2);
        chk("bounce.pos_cnt", npos, 32'd1);
        chk("bounce.overlap", overlap, 32'd0);

        // Full count from 0 through the wrap
        cnt_en = 1'b1;
        for (int i = 1; i <= CMAX; i++) begin
            tick("count");
            chk("count.q",    {12'd0, q},    i);
            chk("count.cout", {31'd0, cout}, (i == CMAX) ? 32'd1 : 32'd0);
        end
        tick("wrap");
        chk("wrap.q", {12'd0, q}, 32'd0);
        cnt_en = 1'b0;
        repeat (3) tick("after_wrap");
        chk("after_wrap.q", {12'd0, q}, 32'd0);
        chk("after_wrap.cout", {31'd0, cout}, 32'd0);

        // Hold at 5, then asynchronous clear between edges
        cnt_en = 1'b1;
        repeat (5) tick("to5");
        cnt_en = 1'b0;
        repeat (4) tick("hold");
        chk("hold.q", {12'd0, q}, 32'd5);
        #2 aclr = 1'b1;
        cnt_m = 0;
        #1 chk("aclr.q", {12'd0, q}, 32'd0);
        #1 aclr = 1'b0;
        cnt_en = 1'b1;
        tick("resume");
        chk("resume.q", {12'd0, q}, 32'd1);

        // Async reset at q=7 with key low
        repeat (6) tick("to7");
        chk("to7.q", {12'd0, q}, 32'd7);
        chk("to7.key", {31'd0, key}, 32'd0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk("arst.q",   {12'd0, q},   32'd0);
        chk("arst.key", {31'd0, key}, 32'd1);
        chk_model("arst");
        #1 rst_n = 1'b1;
        repeat (4) tick("post_rst");

        // Randomized traffic with occasional async clears and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3, 0) == 0) key_in = ~key_in;
            cnt_en = ($urandom_range(3, 0) != 0);
            if ($urandom_range(24, 0) == 0) begin
                #2 aclr = 1'b1;
                cnt_m = 0;
                #1 chk_model("rnd_aclr");
                if ($urandom_range(1, 0) == 0) begin
                    #1 aclr = 1'b0;
                    tick("rnd");
                end else begin
                    tick("rnd_aclr_edge");
                    aclr = 1'b0;
                end
            end else if ($urandom_range(79, 0) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 chk_model("rnd_rst");
                #1 rst_n = 1'b1;
                tick("rnd");
            end else begin
                tick("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
